// File: rtl/rtc_timekeeper_if.sv
// Control/status bundle between the real-time clock core and the display/UI side.
// The UI (master) drives time load, alarm setup and mode; the core (slave)
// returns the current time, strobes and the alarm flag.
interface rtc_timekeeper_if;
  // Run control and display mode
  logic       en;
  logic       mode_12h;

  // Time load request (24-hour values)
  logic       load;
  logic [4:0] load_hh;
  logic [5:0] load_mm;
  logic [5:0] load_ss;

  // Alarm setup and acknowledge
  logic       alarm_en;
  logic [4:0] alarm_hh;
  logic [5:0] alarm_mm;
  logic       alarm_ack;

  // Time and status back to the UI
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [4:0] hours;
  logic       pm;
  logic       sec_pulse;
  logic       day_pulse;
  logic       load_err;
  logic       alarm;

  modport master (
    output en, mode_12h,
    output load, load_hh, load_mm, load_ss,
    output alarm_en, alarm_hh, alarm_mm, alarm_ack,
    input  seconds, minutes, hours, pm,
    input  sec_pulse, day_pulse, load_err, alarm
  );

  modport slave (
    input  en, mode_12h,
    input  load, load_hh, load_mm, load_ss,
    input  alarm_en, alarm_hh, alarm_mm, alarm_ack,
    output seconds, minutes, hours, pm,
    output sec_pulse, day_pulse, load_err, alarm
  );
endinterface

// File: rtl/rtc_timekeeper.sv
// Real-time clock core: divides clk down to a 1 Hz tick and keeps HH:MM:SS.
// Time is held internally in 24-hour form; the 12-hour view is derived
// combinationally so that switching display mode never disturbs state.
// A load request always beats a tick in the same cycle; an invalid load
// freezes everything for that cycle and raises a one-cycle error strobe.
module rtc_timekeeper #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic               clk,
  input  logic               reset,
  rtc_timekeeper_if.slave    bus
);

  localparam int PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICKS_PER_SEC - 1);

  // Load values are only accepted when every field is a legal time.
  function automatic logic time_valid(input logic [4:0] hh,
                                      input logic [5:0] mm,
                                      input logic [5:0] ss);
    return (hh <= 5'd23) && (mm <= 6'd59) && (ss <= 6'd59);
  endfunction

  // 24-hour value to display value: midnight and noon both read 12 in 12-hour mode.
  function automatic logic [4:0] disp_hours(input logic [4:0] h24,
                                            input logic       m12);
    logic [4:0] h;
    h = h24;
    if (m12) begin
      if (h24 == 5'd0)       h = 5'd12;
      else if (h24 > 5'd12)  h = h24 - 5'd12;
    end
    return h;
  endfunction

  logic [PRESC_W-1:0] presc_cnt;
  logic [5:0]         sec_cnt;
  logic [5:0]         min_cnt;
  logic [4:0]         hr24_cnt;
  logic               sec_pulse_r;
  logic               day_pulse_r;
  logic               load_err_r;
  logic               alarm_r;

  logic               tick;
  logic               load_ok;
  logic               load_bad;
  logic               adv;
  logic               sec_wrap;
  logic               min_wrap;
  logic               day_wrap;
  logic [5:0]         sec_nxt;
  logic [5:0]         min_nxt;
  logic [4:0]         hr_nxt;
  logic               alarm_cfg_ok;
  logic               alarm_hit;

  // Tick detection, load qualification and the time one second ahead.
  always_comb begin
    tick      = bus.en && (presc_cnt == PRESC_MAX);
    load_ok   = bus.load && time_valid(bus.load_hh, bus.load_mm, bus.load_ss);
    load_bad  = bus.load && !load_ok;
    adv       = tick && !bus.load;

    sec_wrap  = (sec_cnt == 6'd59);
    min_wrap  = sec_wrap && (min_cnt == 6'd59);
    day_wrap  = min_wrap && (hr24_cnt == 5'd23);

    sec_nxt   = sec_wrap ? 6'd0 : sec_cnt + 6'd1;
    min_nxt   = min_cnt;
    if (sec_wrap)
      min_nxt = (min_cnt == 6'd59) ? 6'd0 : min_cnt + 6'd1;
    hr_nxt    = hr24_cnt;
    if (min_wrap)
      hr_nxt  = (hr24_cnt == 5'd23) ? 5'd0 : hr24_cnt + 5'd1;

    // Out-of-range alarm settings are rejected explicitly so that, e.g.,
    // 07:60 cannot alias onto 08:00.
    alarm_cfg_ok = (bus.alarm_hh <= 5'd23) && (bus.alarm_mm <= 6'd59);
    alarm_hit    = bus.alarm_en && alarm_cfg_ok &&
                   (hr_nxt == bus.alarm_hh) && (min_nxt == bus.alarm_mm) &&
                   (sec_nxt == 6'd0);
  end

  // Prescaler: restarts on an accepted load, freezes on a rejected one or when disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      presc_cnt <= '0;
    else if (load_ok)
      presc_cnt <= '0;
    else if (!load_bad && bus.en)
      presc_cnt <= tick ? '0 : presc_cnt + PRESC_W'(1);
  end

  // Time of day: load takes priority, otherwise advance one second on a tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sec_cnt  <= '0;
      min_cnt  <= '0;
      hr24_cnt <= '0;
    end else if (load_ok) begin
      sec_cnt  <= bus.load_ss;
      min_cnt  <= bus.load_mm;
      hr24_cnt <= bus.load_hh;
    end else if (adv) begin
      sec_cnt  <= sec_nxt;
      min_cnt  <= min_nxt;
      hr24_cnt <= hr_nxt;
    end
  end

  // One-cycle strobes: second advance, midnight rollover and rejected load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sec_pulse_r <= 1'b0;
      day_pulse_r <= 1'b0;
      load_err_r  <= 1'b0;
    end else begin
      sec_pulse_r <= adv;
      day_pulse_r <= adv && day_wrap;
      load_err_r  <= load_bad;
    end
  end

  // Sticky alarm: a tick onto HH:MM:00 sets it and wins over ack/disarm.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      alarm_r <= 1'b0;
    else if (adv && alarm_hit)
      alarm_r <= 1'b1;
    else if (bus.alarm_ack || !bus.alarm_en)
      alarm_r <= 1'b0;
  end

  assign bus.seconds   = sec_cnt;
  assign bus.minutes   = min_cnt;
  assign bus.hours     = disp_hours(hr24_cnt, bus.mode_12h);
  assign bus.pm        = (hr24_cnt >= 5'd12);
  assign bus.sec_pulse = sec_pulse_r;
  assign bus.day_pulse = day_pulse_r;
  assign bus.load_err  = load_err_r;
  assign bus.alarm     = alarm_r;

endmodule

// File: doc/rtc_timekeeper.md
Name: rtc_timekeeper

Overview:
Parametrised successor to the team's basic seconds/minutes counter. It divides the system clock down to a 1 Hz tick and keeps full HH:MM:SS time with correct hour wrap. Adds 12/24-hour display mode, validated time load, day-rollover and per-second strobes, and a sticky alarm. It sits between the system clock domain and the display/UI logic.

Parameters:
TICKS_PER_SEC, 50_000_000, clk cycles per second; must be >= 1; TICKS_PER_SEC=1 means every enabled cycle is a tick.
PRESC_W, $clog2(TICKS_PER_SEC) (min 1), prescaler counter width; derived, not overridden.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high; clears all state.
en  in  1  count enable; low freezes the prescaler and the time.
mode_12h  in  1  1 = 12-hour display, 0 = 24-hour display.
load  in  1  single-cycle request to load set time.
load_hh  in  5  set hours, 24-hour format, 0..23.
load_mm  in  6  set minutes, 0..59.
load_ss  in  6  set seconds, 0..59.
alarm_en  in  1  alarm arm.
alarm_hh  in  5  alarm hours, 24-hour format.
alarm_mm  in  6  alarm minutes.
alarm_ack  in  1  clears the alarm output.
seconds  out  6  0..59, registered.
minutes  out  6  0..59, registered.
hours  out  5  display hours, combinational from internal hours24 and mode_12h.
pm  out  1  hours24 >= 12, valid in both modes.
sec_pulse  out  1  one-cycle strobe per second advance.
day_pulse  out  1  one-cycle strobe on the 23:59:59 -> 00:00:00 wrap.
load_err  out  1  one-cycle strobe when a load is rejected.
alarm  out  1  sticky alarm flag.

Behaviour:
- Reset (async): prescaler=0, seconds=minutes=hours24=0, sec_pulse=day_pulse=load_err=alarm=0. hours output reads 0 in 24-hour mode and 12 in 12-hour mode; pm=0.
- Prescaler: when en=1, counts 0..TICKS_PER_SEC-1 and wraps. tick is asserted in the cycle where prescaler==TICKS_PER_SEC-1 and en=1. When en=0, the prescaler holds.
- On a tick, at the same edge as the prescaler wrap:
  - seconds increments; 59 -> 0 with carry.
  - minutes increments on carry; 59 -> 0 with carry.
  - hours24 increments on carry; 23 -> 0.
- sec_pulse is registered high for exactly the cycle after each tick edge.
- day_pulse is registered high for the cycle after the edge that moves the time to 00:00:00 via a tick.
- Hours display:
  - mode_12h=0: hours = hours24.
  - mode_12h=1: hours24 0 -> 12; 1..12 unchanged; 13..23 -> hours24-12.
  - mode_12h changes take effect combinationally and do not disturb state.
- Load (priority over tick in the same cycle):
  - Valid when load_hh<=23, load_mm<=59 and load_ss<=59. On the next edge, time takes the load values and the prescaler clears to 0. No sec_pulse or day_pulse is generated by a load.
  - Invalid: time and prescaler are unchanged, and load_err is high for one cycle.
  - Load works regardless of en.
  - A tick coinciding with a valid load is discarded.
- Alarm:
  - Set when alarm_en=1 and a tick edge moves the time to alarm_hh:alarm_mm:00. A load to that time does not set it.
  - Stays high until alarm_ack=1 or alarm_en=0, cleared at the next edge.
  - If set and clear conditions occur in the same cycle, set wins.
  - Out-of-range alarm values never match.
- Reset mid-operation: all state clears immediately, regardless of load, tick or alarm.

Test Plan:
1. TICKS_PER_SEC=4; release reset with en=1 -> sec_pulse every 4 cycles; seconds 0,1,2,... steps on every 4th edge; seconds, minutes and hours all 0 before the first tick.
2. Load 23:59:58, run 2 ticks -> 23:59:59, then 00:00:00 with day_pulse high for 1 cycle. mode_12h=1 reads hours 11 pm=1, then 12 pm=0.
3. Load 13:05:00 with mode_12h toggled -> hours reads 13 in 24-hour mode and 1 in 12-hour mode, pm=1 in both. Load 24:00:00 -> load_err for 1 cycle, time unchanged. Load 10:60:00 -> load_err.
4. Assert load together with a tick cycle (load 05:00:00) -> time=05:00:00, prescaler restarts, next sec_pulse is 4 cycles later, no pulse on the load edge.
5. alarm_en=1, alarm 07:30; load 07:29:58, 2 ticks -> alarm rises at 07:30:00 and holds. alarm_ack together with a new match -> alarm stays 1. alarm_ack alone -> 0 next edge. Loading 07:30:00 directly -> no alarm.
6. en=0 for 10 cycles mid-count -> seconds and prescaler hold, no pulses. Assert reset mid-count with load=1 -> all outputs clear asynchronously and the load is ignored.
